// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and the logic it controls.
// The master side drives the PLL lock flag. The slave side is the sequencer, which drives the resets and enables.
interface pll_reset_sequencer_if;
    logic locked;
    logic mem_reset;
    logic core_reset;
    logic ce_ppu;
    logic ce_cpu;
    logic ready;
    logic lock_lost;

    modport master (
        output locked,
        input  mem_reset,
        input  core_reset,
        input  ce_ppu,
        input  ce_cpu,
        input  ready,
        input  lock_lost
    );

    modport slave (
        input  locked,
        output mem_reset,
        output core_reset,
        output ce_ppu,
        output ce_cpu,
        output ready,
        output lock_lost
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Qualifies PLL lock, releases the memory reset and then the core reset, and generates the PPU/CPU clock enables.
// Any loss of lock pulls everything back into reset and sets a sticky fault flag.
module pll_reset_sequencer #(
    parameter int unsigned SYNC_STAGES        = 2,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned MEM_INIT_CYCLES    = 64,
    parameter int unsigned PPU_DIV            = 8,
    parameter int unsigned CPU_DIV            = 24
) (
    input logic                  clock_in,
    input logic                  reset_n,
    pll_reset_sequencer_if.slave bus
);

    localparam int unsigned CNT_MAX = (LOCK_STABLE_CYCLES > MEM_INIT_CYCLES) ?
                                      LOCK_STABLE_CYCLES : MEM_INIT_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned PPU_W   = $clog2(PPU_DIV);
    localparam int unsigned CPU_W   = $clog2(CPU_DIV);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        MEM_INIT  = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [PPU_W-1:0]       ppu_cnt_q, ppu_cnt_d;
    logic [CPU_W-1:0]       cpu_cnt_q, cpu_cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;

    logic mem_reset_q, mem_reset_d;
    logic core_reset_q, core_reset_d;
    logic ce_ppu_q, ce_ppu_d;
    logic ce_cpu_q, ce_cpu_d;
    logic ready_q, ready_d;
    logic lock_lost_q, lock_lost_d;

    assign locked_s = sync_q[SYNC_STAGES-1];

    // Lock synchronizer, shifting towards the MSB
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.locked};
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= WAIT_LOCK;
            cnt_q        <= '0;
            ppu_cnt_q    <= '0;
            cpu_cnt_q    <= '0;
            mem_reset_q  <= 1'b1;
            core_reset_q <= 1'b1;
            ce_ppu_q     <= 1'b0;
            ce_cpu_q     <= 1'b0;
            ready_q      <= 1'b0;
            lock_lost_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ppu_cnt_q    <= ppu_cnt_d;
            cpu_cnt_q    <= cpu_cnt_d;
            mem_reset_q  <= mem_reset_d;
            core_reset_q <= core_reset_d;
            ce_ppu_q     <= ce_ppu_d;
            ce_cpu_q     <= ce_cpu_d;
            ready_q      <= ready_d;
            lock_lost_q  <= lock_lost_d;
        end
    end

    // Next state, counters and output values
    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        ppu_cnt_d    = '0;
        cpu_cnt_d    = '0;

        unique case (state_q)
            WAIT_LOCK: if (locked_s) state_d = STABLE;
            STABLE: begin
                if (!locked_s)                                       state_d = WAIT_LOCK;
                else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1))    state_d = MEM_INIT;
                else                                                 cnt_d   = cnt_q + CNT_W'(1);
            end
            MEM_INIT: begin
                if (!locked_s)                                       state_d = WAIT_LOCK;
                else if (cnt_q == CNT_W'(MEM_INIT_CYCLES - 1))       state_d = RUN;
                else                                                 cnt_d   = cnt_q + CNT_W'(1);
            end
            RUN: if (!locked_s) state_d = WAIT_LOCK;
            default: state_d = WAIT_LOCK;
        endcase

        // Dividers only count while already in RUN, so the phase restarts on every entry
        if (state_q == RUN) begin
            ppu_cnt_d = (ppu_cnt_q == PPU_W'(PPU_DIV - 1)) ? '0 : ppu_cnt_q + PPU_W'(1);
            cpu_cnt_d = (cpu_cnt_q == CPU_W'(CPU_DIV - 1)) ? '0 : cpu_cnt_q + CPU_W'(1);
        end

        mem_reset_d  = !((state_d == MEM_INIT) || (state_d == RUN));
        core_reset_d = (state_d != RUN);
        ready_d      = (state_d == RUN);
        ce_ppu_d     = (state_q == RUN) && (state_d == RUN) && (ppu_cnt_q == PPU_W'(PPU_DIV - 1));
        ce_cpu_d     = (state_q == RUN) && (state_d == RUN) && (cpu_cnt_q == CPU_W'(CPU_DIV - 1));
        lock_lost_d  = lock_lost_q || ((state_q == RUN) && !locked_s);
    end

    assign bus.mem_reset  = mem_reset_q;
    assign bus.core_reset = core_reset_q;
    assign bus.ce_ppu     = ce_ppu_q;
    assign bus.ce_cpu     = ce_cpu_q;
    assign bus.ready      = ready_q;
    assign bus.lock_lost  = lock_lost_q;

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the iCE40 PLL wrapper. Runs on the PLL output clock and consumes its `locked` flag.
- Qualifies lock: synchronizes it and requires it to be stable before use.
- Releases staged synchronous resets: memory/video RAM side first, then the NES core.
- Once running, generates the PPU and CPU clock-enable strobes from the ~43 MHz PLL clock.
- Any loss of lock re-asserts both resets and records a sticky fault flag.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the `locked` synchronizer (>=2).
- LOCK_STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before releasing mem_reset (>=1).
- MEM_INIT_CYCLES, 64, cycles between mem_reset release and core_reset release (>=1).
- PPU_DIV, 8, clock_in cycles per ce_ppu pulse (>=2).
- CPU_DIV, 24, clock_in cycles per ce_cpu pulse (>=2, integer multiple of PPU_DIV).

Ports:
- clock_in  in  1  PLL output clock; one clock, all logic on rising edge.
- reset_n  in  1  reset, asynchronous and active-low; clears every flop including the synchronizer.
- locked  in  1  PLL lock flag; treated as asynchronous.
- mem_reset  out  1  active-high synchronous reset for RAM/video-side logic.
- core_reset  out  1  active-high synchronous reset for the CPU/PPU core.
- ce_ppu  out  1  single-cycle PPU clock enable.
- ce_cpu  out  1  single-cycle CPU clock enable.
- ready  out  1  high while in RUN.
- lock_lost  out  1  sticky; set on lock loss while in RUN.

Behaviour:
- Reset values (asserted asynchronously on reset_n low):
  - mem_reset=1, core_reset=1, ce_ppu=0, ce_cpu=0, ready=0, lock_lost=0.
  - State = WAIT_LOCK; all counters 0; synchronizer flops 0.
- locked_s is the output of a SYNC_STAGES-deep synchronizer. All FSM decisions use locked_s only.
- All outputs are registered. Counter widths are $clog2 of their maximum terminal value, with no overflow possible.
- FSM states:
  - WAIT_LOCK: mem_reset=1, core_reset=1. If locked_s=1, go to STABLE with cnt=0.
  - STABLE: mem_reset=1, core_reset=1.
    - cnt increments each cycle.
    - When cnt==LOCK_STABLE_CYCLES-1 with locked_s=1, go to MEM_INIT with cnt=0.
    - STABLE therefore lasts exactly LOCK_STABLE_CYCLES cycles.
  - MEM_INIT: mem_reset=0, core_reset=1. Lasts exactly MEM_INIT_CYCLES cycles, then go to RUN.
  - RUN: mem_reset=0, core_reset=0, ready=1. Divider counters run.
- Lock loss: locked_s=0 in any state other than WAIT_LOCK means:
  - At the next edge, go to WAIT_LOCK with cnt=0.
  - mem_reset and core_reset both go 1 and ready goes 0 at that same edge.
  - ce outputs are 0 from that edge.
  - A single-cycle drop in STABLE restarts qualification from zero.
- lock_lost is set at the edge where RUN is left due to locked_s=0. It is cleared only by reset_n.
- Dividers:
  - ppu_cnt and cpu_cnt are forced to 0 on every edge where the state is not RUN, including the edge that enters RUN.
  - In RUN, each counter counts 0..DIV-1 and wraps.
  - The ce register is set to 1 for one cycle at the edge where its counter wraps DIV-1 to 0, else 0.
  - First ce_ppu is high PPU_DIV cycles after core_reset falls; first ce_cpu is high CPU_DIV cycles after.
  - Every (CPU_DIV/PPU_DIV)-th ce_ppu coincides with ce_cpu.
- Lock glitches during reset_n low are ignored.
- Lock re-acquired after loss repeats the full STABLE→MEM_INIT→RUN sequence. Divider phase restarts from 0.
- Latency from locked rising (held high) to mem_reset falling: SYNC_STAGES+1+LOCK_STABLE_CYCLES edges.

Test Plan:
(Params SYNC_STAGES=2, LOCK_STABLE_CYCLES=16, MEM_INIT_CYCLES=4, PPU_DIV=8, CPU_DIV=24 unless noted.)
1. Power-up: reset_n=0, locked=1 for 5 cycles → mem_reset=core_reset=1, ready=0, no ce pulses. Release reset_n at edge 0, locked held 1 → mem_reset falls after edge 19, core_reset and ready after edge 23.
2. Enables in RUN → ce_ppu high in cycles after edges 31, 39, 47, …; ce_cpu after edges 47, 71, …; both high together after edge 47; each pulse exactly 1 cycle wide.
3. Qualification glitch: locked low for 1 cycle mid-STABLE → STABLE restarts from cnt=0. mem_reset falls 16+SYNC latency cycles after locked returns. lock_lost stays 0.
4. Lock loss in RUN: drop locked → mem_reset, core_reset=1 and ready=0 exactly 3 edges after the drop (2 sync + 1); ce outputs 0; lock_lost=1. Restore locked → full sequence repeats; first ce_ppu 8 cycles after core_reset falls; lock_lost remains 1.
5. Async reset mid-MEM_INIT: assert reset_n between edges → all outputs at reset values immediately without a clock edge; lock_lost=0.
6. Parameter sweep PPU_DIV=2, CPU_DIV=6, LOCK_STABLE_CYCLES=1, MEM_INIT_CYCLES=1 → STABLE and MEM_INIT each last 1 cycle; ce_ppu every 2nd cycle; ce_cpu every 6th cycle, coincident with every 3rd ce_ppu.
